// File: rtl/minaret_pkg.sv
// Shared types and widths for the minaret cache front end.
// The arbiter state encoding lives here so other blocks can decode it.
package minaret_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    localparam int CACHE_ADDR_W = 29;
    localparam int WMASK_W      = 4;
    localparam int DATA_W       = 32;
    localparam int STREAK_W     = 4;

endpackage

// File: rtl/cache_arbiter.sv
// Grant-locked arbiter between the CPU instruction and data ports and the
// single cache_control request port, with data priority and bounded starvation.
module cache_arbiter
    import minaret_pkg::*;
#(
    parameter int ADDR_W     = CACHE_ADDR_W,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               resetn,

    input  logic               i_valid,
    output logic               i_ready,
    input  logic [ADDR_W-1:0]  i_addr,
    output logic [DATA_W-1:0]  i_rdata,

    input  logic               d_valid,
    output logic               d_ready,
    input  logic [ADDR_W-1:0]  d_addr,
    input  logic [WMASK_W-1:0] d_wmask,
    input  logic [DATA_W-1:0]  d_wdata,
    output logic [DATA_W-1:0]  d_rdata,

    output logic               c_valid,
    input  logic               c_ready,
    output logic [ADDR_W-1:0]  c_addr,
    output logic [WMASK_W-1:0] c_wmask,
    output logic [DATA_W-1:0]  c_wdata,
    input  logic [DATA_W-1:0]  c_rdata
);

    arb_state_t            state;
    arb_state_t            state_next;
    logic [STREAK_W-1:0]   streak;
    logic                  starved;
    logic                  grant_i;
    logic                  grant_d;

    assign starved = (streak == STREAK_W'(STARVE_MAX));

    // Grants are only made from IDLE, which guarantees one idle cycle between
    // transactions so a requester's valid from its ready cycle is never re-granted.
    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (d_valid && !(i_valid && starved)) begin
                    grant_d    = 1'b1;
                    state_next = BUSY_D;
                end else if (i_valid) begin
                    grant_i    = 1'b1;
                    state_next = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (c_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counts data grants that overtook a waiting instruction fetch.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            streak <= '0;
        end else if (grant_i) begin
            streak <= '0;
        end else if (grant_d && i_valid && !starved) begin
            streak <= streak + STREAK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            c_addr  <= '0;
            c_wmask <= '0;
            c_wdata <= '0;
        end else if (grant_d) begin
            c_addr  <= d_addr;
            c_wmask <= d_wmask;
            c_wdata <= d_wdata;
        end else if (grant_i) begin
            c_addr  <= i_addr;
            c_wmask <= '0;
            c_wdata <= '0;
        end
    end

    // Responses are steered combinationally so ready lands in the cache's completion cycle.
    assign c_valid = (state != IDLE);
    assign i_ready = c_ready && (state == BUSY_I);
    assign d_ready = c_ready && (state == BUSY_D);
    assign i_rdata = (state == BUSY_I) ? c_rdata : '0;
    assign d_rdata = (state == BUSY_D) ? c_rdata : '0;

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-port arbiter between the CPU instruction port and data port and the single request port of `cache_control`. It replaces the combinational imem/dmem steering in front of the cache with a registered, grant-locked arbiter. Data requests take priority, and a bounded-starvation rule guarantees instruction fetches make forward progress. Read data and ready are routed back only to the granted requester.

## Interface

Parameters:
- `ADDR_W`, 29: width of the cache-side byte address.
- `STARVE_MAX`, 4: consecutive data grants allowed while an instruction request is pending before an instruction grant is forced. Legal range 1–15.

Ports:
- `clk`  in  1  single clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `i_valid`  in  1  instruction request.
- `i_ready`  out  1  instruction response strobe.
- `i_addr`  in  ADDR_W  instruction address.
- `i_rdata`  out  32  instruction read data.
- `d_valid`  in  1  data request.
- `d_ready`  out  1  data response strobe.
- `d_addr`  in  ADDR_W  data address.
- `d_wmask`  in  4  byte write mask; 0 means read.
- `d_wdata`  in  32  write data.
- `d_rdata`  out  32  data read data.
- `c_valid`  out  1  request to `cache_control`.
- `c_ready`  in  1  cache completion strobe.
- `c_addr`  out  ADDR_W  registered address.
- `c_wmask`  out  4  registered mask; forced to 0 on instruction grants.
- `c_wdata`  out  32  registered write data; forced to 0 on instruction grants.
- `c_rdata`  in  32  cache read data.

## Operation

- **Handshake (all ports):** the requester holds valid and its payload stable until ready. Ready is a single-cycle pulse. Valid seen in the cycle after ready is treated as a new request.
- **FSM states:** `IDLE`, `BUSY_I`, `BUSY_D`.
- **`IDLE` transitions:**
  - Only `d_valid` → `BUSY_D`.
  - Only `i_valid` → `BUSY_I`.
  - Both valid → `BUSY_D`, unless `streak == STARVE_MAX`, in which case → `BUSY_I`.
  - On every grant, the granted payload is captured into the `c_addr`/`c_wmask`/`c_wdata` registers.
- **`BUSY_x` transitions:** `c_valid = 1`. On `c_ready`, go to `IDLE`. A grant is never issued directly from `BUSY`, so there is always one `IDLE` cycle between transactions. This prevents stale valids from being re-granted.
- **Response routing (combinational):**
  - `i_ready = c_ready & (state == BUSY_I)`; `d_ready = c_ready & (state == BUSY_D)`.
  - `i_rdata = (state == BUSY_I) ? c_rdata : 0`; `d_rdata` is the mirror.
- **`streak` counter (4 bits):**
  - Increments, saturating at `STARVE_MAX`, on a data grant made while `i_valid` = 1.
  - Clears on any instruction grant.
  - Unchanged on a data grant with `i_valid` = 0.
- **Requester drops valid mid-transaction (protocol violation):** the cache transaction still completes, the ready pulse is still emitted, and the FSM returns to `IDLE`. No corruption occurs.
- **Reset:** the FSM and `streak` reset unconditionally. The cache side must itself be reset by the same `resetn`.

## Timing

- **Reset values:**
  - state `IDLE`, `streak` 0.
  - `c_valid` 0, `c_addr` 0, `c_wmask` 0, `c_wdata` 0.
  - `i_ready` and `d_ready` 0; `i_rdata` and `d_rdata` 0.
- **Latency:**
  - A request arriving in `IDLE` at cycle N gives `c_valid` = 1 at N+1.
  - If the cache answers at N+k, the requester's ready is also at N+k, combinationally from `c_ready`.
  - The earliest next grant is decided in `IDLE` at N+k+1, with `c_valid` at N+k+2.
- **Simultaneous request:** with both valid in the same `IDLE` cycle, exactly one grant is issued. The loser keeps valid asserted and is served after the current transaction.
- **`c_ready` outside `BUSY`:** ignored; no ready pulse is produced.
- **Reset asserted mid-transaction:** `c_valid` drops asynchronously. No ready pulse is emitted for the aborted request.

## Structure

- **Shared package `minaret_pkg`:**
  - `arb_state_t` enum holding `IDLE`, `BUSY_I`, `BUSY_D`.
  - `CACHE_ADDR_W = 29`.
  - `WMASK_W = 4`.
- **Sub-modules:** none required. The grant decision is a small always block; the payload register bank sits in the same module.

## Test plan

- **Reset:** assert `resetn` = 0 asynchronously mid-transaction → `c_valid`, `i_ready`, `d_ready` are 0 immediately; state `IDLE` after release.
- **Single instruction fetch:** `i_valid` with `i_addr` = 0x100 at cycle 0, cache `c_ready` at cycle 3 with `c_rdata` = 0xDEADBEEF → `c_addr` = 0x100, `c_wmask` = 0; `i_ready` = 1 with `i_rdata` = 0xDEADBEEF at cycle 3; `d_ready` stays 0.
- **Data write:** `d_valid`, `d_addr` = 0x204, `d_wmask` = 0xC, `d_wdata` = 0x12345678 → `c_wmask` = 0xC, `c_wdata` = 0x12345678 from cycle 1 until `c_ready`; exactly one `d_ready` pulse.
- **Simultaneous request:** `i_valid` and `d_valid` asserted together in `IDLE`, `streak` = 0 → data served first, instruction granted in the `IDLE` cycle after `d_ready`; `streak` = 1, then 0.
- **Starvation:** `i_valid` held high while `d_valid` re-requests continuously, `STARVE_MAX` = 4 → grant order D, D, D, D, I, D…; the instruction completes within 5 transactions.
- **Stray and aborted traffic:** `c_ready` pulsed in `IDLE` → no ready outputs. Separately, `d_valid` dropped mid-`BUSY_D` → the transaction completes, the FSM returns to `IDLE`, and a subsequent instruction request is served normally.
